// File: rtl/score_pkg.sv
// Shared constants and state encoding for the score/line bookkeeping stage.
package score_pkg;

  // Default points awarded for a 1/2/3/4-line clear.
  localparam int unsigned PTS1_DEF = 1;
  localparam int unsigned PTS2_DEF = 3;
  localparam int unsigned PTS3_DEF = 5;
  localparam int unsigned PTS4_DEF = 8;

  // Pending-points counter is 4 bits wide and saturates here.
  localparam int unsigned PEND_MAX = 15;

  // Largest two-digit packed-BCD value; score and line count stop here.
  localparam logic [7:0] BCD_MAX = 8'h99;

  typedef enum logic {
    IDLE = 1'b0,
    ADD  = 1'b1
  } state_e;

endpackage

// File: rtl/score_bcd_bcd2_add_sat.sv
// Two-digit packed-BCD adder with a small (0..4) addend, saturating at 99.
module bcd2_add_sat
  import score_pkg::*;
(
  input  logic [7:0] a_i,
  input  logic [2:0] b_i,
  output logic [7:0] y_o
);

  logic [4:0] units_sum;
  logic [4:0] tens_sum;

  // Add into the units digit, carry a decimal overflow into tens, clamp at 99.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    y_o       = BCD_MAX;
    units_sum = {1'b0, a_i[3:0]} + {2'b00, b_i};
    tens_sum  = {1'b0, a_i[7:4]};
    if (units_sum >= 5'd10) begin
      units_sum = units_sum - 5'd10;
      tens_sum  = tens_sum + 5'd1;
    end
    if (tens_sum < 5'd10) begin
      y_o = {tens_sum[3:0], units_sum[3:0]};
    end
  end

endmodule

// File: rtl/score_bcd.sv
// Score/line bookkeeping feeding the two-digit 7-segment display interface.
// Line clears queue points in a pending counter; an IDLE/ADD FSM drains it
// one BCD increment per cycle so the display visibly counts up.
module score_bcd
  import score_pkg::*;
#(
  parameter int unsigned PTS1 = PTS1_DEF,
  parameter int unsigned PTS2 = PTS2_DEF,
  parameter int unsigned PTS3 = PTS3_DEF,
  parameter int unsigned PTS4 = PTS4_DEF
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       clr_valid,
  input  logic [2:0] clr_lines,
  input  logic       new_game,
  input  logic       disp_sel,
  output logic [7:0] num,
  output logic [3:0] level,
  output logic       busy,
  output logic [7:0] score
);

  localparam logic [3:0] P1 = 4'(PTS1);
  localparam logic [3:0] P2 = 4'(PTS2);
  localparam logic [3:0] P3 = 4'(PTS3);
  localparam logic [3:0] P4 = 4'(PTS4);

  state_e     state_q, state_d;
  logic [7:0] score_q, score_d;
  logic [7:0] lines_q, lines_d;
  logic [7:0] best_q, best_d;
  logic [3:0] pend_q, pend_d;
  logic [3:0] level_q;
  logic       busy_q;
  logic [7:0] num_q;

  logic [7:0] score_inc;
  logic [7:0] lines_add;
  logic [3:0] pts;
  logic       clr_ok;
  logic       dec;
  logic [5:0] pend_sum;

  bcd2_add_sat u_score_inc (
    .a_i (score_q),
    .b_i (3'd1),
    .y_o (score_inc)
  );

  bcd2_add_sat u_lines_add (
    .a_i (lines_q),
    .b_i (clr_lines),
    .y_o (lines_add)
  );

  // Decode a line-clear strobe into points; out-of-range line counts are ignored.
  always_comb begin
    pts    = 4'd0;
    clr_ok = 1'b0;
    if (clr_valid) begin
      unique case (clr_lines)
        3'd1:    begin pts = P1; clr_ok = 1'b1; end
        3'd2:    begin pts = P2; clr_ok = 1'b1; end
        3'd3:    begin pts = P3; clr_ok = 1'b1; end
        3'd4:    begin pts = P4; clr_ok = 1'b1; end
        default: begin pts = 4'd0; clr_ok = 1'b0; end
      endcase
    end
  end

  // Pending points: drain one per ADD cycle, add new points, clamp at PEND_MAX.
  always_comb begin
    dec      = (state_q == ADD) && (pend_q != 4'd0);
    pend_sum = {2'b00, pend_q} - {5'b0, dec} + {2'b00, pts};
    if (pend_sum > 6'(PEND_MAX)) begin
      pend_sum = 6'(PEND_MAX);
    end
  end

  // Next-state: new_game wins over everything, otherwise run the IDLE/ADD FSM.
  always_comb begin
    state_d = state_q;
    score_d = score_q;
    lines_d = lines_q;
    best_d  = best_q;
    pend_d  = pend_q;
    if (new_game) begin
      if (score_q > best_q) begin
        best_d = score_q;
      end
      score_d = 8'h00;
      lines_d = 8'h00;
      pend_d  = 4'd0;
      state_d = IDLE;
    end else begin
      pend_d = pend_sum[3:0];
      if (clr_ok) begin
        lines_d = lines_add;
      end
      unique case (state_q)
        IDLE: begin
          if (pend_q != 4'd0) begin
            state_d = ADD;
          end
        end
        ADD: begin
          score_d = score_inc;
          if (pend_d == 4'd0) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and bookkeeping registers; busy and level follow the next-state values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      score_q <= 8'h00;
      lines_q <= 8'h00;
      best_q  <= 8'h00;
      pend_q  <= 4'd0;
      level_q <= 4'd0;
      busy_q  <= 1'b0;
      num_q   <= 8'h00;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
      state_q <= state_d;
      score_q <= score_d;
      lines_q <= lines_d;
      best_q  <= best_d;
      pend_q  <= pend_d;
      level_q <= lines_d[7:4];
      busy_q  <= (state_d == ADD) || (pend_d != 4'd0);
      num_q   <= disp_sel ? best_q : score_q;
    end
  end

  assign num   = num_q;
  assign level = level_q;
  assign busy  = busy_q;
  assign score = score_q;

endmodule

// File: tb/tb_score_bcd.sv
// Directed bench for score_bcd: a table of single line-clear vectors plus
// hand-written cycle-accurate sequences for latency, accumulation,
// saturation, new_game and mid-ADD reset.
module tb_score_bcd;

  logic       clk = 1'b0;
  logic       rstn;
  logic       clr_valid;
  logic [2:0] clr_lines;
  logic       new_game;
  logic       disp_sel;
  logic [7:0] num;
  logic [3:0] level;
  logic       busy;
  logic [7:0] score;

  int n_vec = 0;
  int n_err = 0;

  score_bcd dut (
    .clk       (clk),
    .rstn      (rstn),
    .clr_valid (clr_valid),
    .clr_lines (clr_lines),
    .new_game  (new_game),
    .disp_sel  (disp_sel),
    .num       (num),
    .level     (level),
    .busy      (busy),
    .score     (score)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] cl;
    logic [7:0] exp_score;
    logic [7:0] exp_lines;
    logic [3:0] exp_level;
  } vec_t;

  vec_t vt[10];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int n);
    return 8'(((n / 10) << 4) | (n % 10));
  endfunction

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle clear strobe; returns just after the sampling edge.
  task automatic strobe(input logic [2:0] n);
    clr_valid = 1'b1;
    clr_lines = n;
    tick();
    clr_valid = 1'b0;
    clr_lines = 3'd0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy === 1'b1 && n < 200) begin
      tick();
      n++;
    end
    check("wait_idle", 8'(busy), 8'h00);
  endtask

  task automatic pulse_new_game();
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
  endtask

  task automatic show_best(input logic [7:0] exp, input string name);
    disp_sel = 1'b1;
    tick();
    check(name, num, exp);
    disp_sel = 1'b0;
  endtask

  task automatic apply_vec(input int i);
    strobe(vt[i].cl);
    wait_idle();
    check($sformatf("vec%0d_score", i), score, vt[i].exp_score);
    check($sformatf("vec%0d_lines", i), dut.lines_q, vt[i].exp_lines);
    check($sformatf("vec%0d_level", i), 8'(level), 8'(vt[i].exp_level));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] steps[8];
    steps = '{8'h08, 8'h09, 8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15};

    vt[0] = '{3'd3, 8'h06, 8'h04, 4'd0};
    vt[1] = '{3'd1, 8'h07, 8'h05, 4'd0};
    vt[2] = '{3'd0, 8'h07, 8'h05, 4'd0};
    vt[3] = '{3'd5, 8'h07, 8'h05, 4'd0};
    vt[4] = '{3'd7, 8'h07, 8'h05, 4'd0};
    vt[5] = '{3'd6, 8'h07, 8'h05, 4'd0};
    vt[6] = '{3'd1, 8'h16, 8'h10, 4'd1};
    vt[7] = '{3'd2, 8'h19, 8'h12, 4'd1};
    vt[8] = '{3'd2, 8'h22, 8'h14, 4'd1};
    vt[9] = '{3'd4, 8'h30, 8'h18, 4'd1};

    rstn = 1'b0; clr_valid = 1'b0; clr_lines = 3'd0; new_game = 1'b0; disp_sel = 1'b0;
    repeat (2) tick();
    check("rst_score", score, 8'h00);
    check("rst_num",   num,   8'h00);
    check("rst_level", 8'(level), 8'h00);
    check("rst_busy",  8'(busy),  8'h00);
    rstn = 1'b1;
    tick();

    // Single-line clear latency: busy from k, score at k+2, num at k+3.
    strobe(3'd1);
    check("lat_k_busy",   8'(busy), 8'h01);
    check("lat_k_lines",  dut.lines_q, 8'h01);
    check("lat_k_score",  score, 8'h00);
    tick();
    check("lat_k1_score", score, 8'h00);
    check("lat_k1_busy",  8'(busy), 8'h01);
    tick();
    check("lat_k2_score", score, 8'h01);
    check("lat_k2_busy",  8'(busy), 8'h00);
    check("lat_k2_num",   num, 8'h00);
    tick();
    check("lat_k3_num",   num, 8'h01);

    for (int i = 0; i < 6; i++) apply_vec(i);

    // 4-line clear from 07: BCD stepping through 15.
    strobe(3'd4);
    check("step_k_score", score, 8'h07);
    tick();
    check("step_k1_score", score, 8'h07);
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("step%0d", i), score, steps[i]);
    end
    check("step_busy_end", 8'(busy), 8'h00);
    check("step_lines", dut.lines_q, 8'h09);

    for (int i = 6; i < 10; i++) apply_vec(i);

    // new_game while idle: best takes 30.
    pulse_new_game();
    check("ng1_score", score, 8'h00);
    check("ng1_lines", dut.lines_q, 8'h00);
    check("ng1_level", 8'(level), 8'h00);
    show_best(8'h30, "ng1_best");
    tick();
    check("ng1_num_score", num, 8'h00);

    // Ten single-line clears.
    for (int i = 1; i <= 10; i++) begin
      strobe(3'd1);
      wait_idle();
      check($sformatf("single%0d_lines", i), dut.lines_q, to_bcd(i));
      check($sformatf("single%0d_score", i), score, to_bcd(i));
    end
    check("single_level", 8'(level), 8'h01);
    strobe(3'd0);
    check("ign0_busy", 8'(busy), 8'h00);
    check("ign0_lines", dut.lines_q, 8'h10);
    strobe(3'd5);
    check("ign5_busy", 8'(busy), 8'h00);
    tick();
    check("ign5_lines", dut.lines_q, 8'h10);
    check("ign5_score", score, 8'h10);

    for (int i = 0; i < 4; i++) begin
      strobe(3'd4);
      wait_idle();
    end
    check("pre_ng2_score", score, 8'h42);

    // new_game with a same-cycle clear while an ADD is in progress.
    strobe(3'd4);
    tick();
    new_game = 1'b1; clr_valid = 1'b1; clr_lines = 3'd2;
    tick();
    new_game = 1'b0; clr_valid = 1'b0; clr_lines = 3'd0;
    check("ng2_score", score, 8'h00);
    check("ng2_lines", dut.lines_q, 8'h00);
    check("ng2_level", 8'(level), 8'h00);
    check("ng2_busy",  8'(busy), 8'h00);
    show_best(8'h42, "ng2_best");
    repeat (12) tick();
    check("ng2_drop_score", score, 8'h00);
    check("ng2_drop_busy",  8'(busy), 8'h00);
    check("ng2_drop_lines", dut.lines_q, 8'h00);

    // Second clear arriving mid-ADD accumulates: 16 points total.
    strobe(3'd4);
    tick();
    tick();
    strobe(3'd4);
    wait_idle();
    check("acc_score", score, 8'h16);
    check("acc_lines", dut.lines_q, 8'h08);

    // Pending saturates: pend reaches 14, then a 4-line clear clamps at 15.
    clr_valid = 1'b1; clr_lines = 3'd4; tick();
    clr_lines = 3'd3; tick();
    clr_valid = 1'b0; clr_lines = 3'd0; tick();
    clr_valid = 1'b1; clr_lines = 3'd2; tick();
    clr_lines = 3'd4; tick();
    clr_valid = 1'b0; clr_lines = 3'd0;
    wait_idle();
    check("psat_score", score, 8'h34);
    check("psat_lines", dut.lines_q, 8'h21);
    check("psat_level", 8'(level), 8'h02);

    pulse_new_game();
    show_best(8'h42, "ng3_best_kept");

    // Score saturation at 99.
    for (int i = 0; i < 12; i++) begin
      strobe(3'd4);
      wait_idle();
    end
    check("fill_score", score, 8'h96);
    strobe(3'd1);
    wait_idle();
    check("fill97_score", score, 8'h97);
    strobe(3'd3);
    tick();
    tick();
    check("sat_k2", score, 8'h98);
    tick();
    check("sat_k3", score, 8'h99);
    tick();
    tick();
    check("sat_k5_busy",  8'(busy), 8'h01);
    check("sat_k5_score", score, 8'h99);
    tick();
    check("sat_k6_busy",  8'(busy), 8'h00);
    check("sat_k6_score", score, 8'h99);

    // Line count saturation at 99.
    for (int i = 0; i < 12; i++) begin
      strobe(3'd4);
      wait_idle();
    end
    check("lsat_lines", dut.lines_q, 8'h99);
    check("lsat_level", 8'(level), 8'h09);
    check("lsat_score", score, 8'h99);
    strobe(3'd1);
    check("lsat_again", dut.lines_q, 8'h99);
    wait_idle();
    check("lsat_num", num, 8'h99);
    pulse_new_game();
    show_best(8'h99, "ng4_best");

    // Asynchronous reset in the middle of an ADD.
    strobe(3'd4);
    tick();
    tick();
    #2;
    rstn = 1'b0;
    #1;
    check("arst_score", score, 8'h00);
    check("arst_lines", dut.lines_q, 8'h00);
    check("arst_level", 8'(level), 8'h00);
    check("arst_busy",  8'(busy), 8'h00);
    check("arst_num",   num, 8'h00);
    tick();
    rstn = 1'b1;
    repeat (10) tick();
    check("arst_after_score", score, 8'h00);
    check("arst_after_busy",  8'(busy), 8'h00);
    show_best(8'h00, "arst_best");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
